// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, RV32I load/store funct3 codes and size decode for the LSU
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} lsu_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Reserved encodings fall through to a word access.
    function automatic lsu_size_t funct3_to_size(input logic we, input logic [2:0] f3);
        lsu_size_t sz;
        sz = SZ_W;
        if (we) begin
            if (f3 == F3_SB)      sz = SZ_B;
            else if (f3 == F3_SH) sz = SZ_H;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_B;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_H;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and data_memory port bundle for the LSU
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              i_Valid;
    logic              o_Ready;
    logic              i_We;
    logic [2:0]        i_Funct3;
    logic [ADDR_W-1:0] i_Addr;
    logic [31:0]       i_Wdata;
    logic              o_Done;
    logic [31:0]       o_Rdata;
    logic              o_Err;
    logic [ADDR_W-1:0] o_Addr;
    logic [31:0]       o_Wd;
    logic [3:0]        o_Be;
    logic              o_Ren;
    logic              o_Wen;
    logic [31:0]       i_Rd;

    modport slave (
        input  i_Valid, i_We, i_Funct3, i_Addr, i_Wdata, i_Rd,
        output o_Ready, o_Done, o_Rdata, o_Err, o_Addr, o_Wd, o_Be, o_Ren, o_Wen
    );

    modport master (
        output i_Valid, i_We, i_Funct3, i_Addr, i_Wdata, i_Rd,
        input  o_Ready, o_Done, o_Rdata, o_Err, o_Addr, o_Wd, o_Be, o_Ren, o_Wen
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane steering: byte enables, store replication, load extract/extend
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_t   size,
    input  logic [1:0]  off,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wd,
    output logic [31:0] ld
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rd[{off, 3'b000} +: 8];
        half_v = rd[{off[1], 4'b0000} +: 16];
        be     = 4'hF;
        wd     = wdata;
        ld     = rd;
        case (size)
            SZ_B: begin
                be = 4'b0001 << off;
                wd = {4{wdata[7:0]}};
                ld = {{24{sext & byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                be = 4'b0011 << {off[1], 1'b0};
                wd = {2{wdata[15:0]}};
                ld = {{16{sext & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - LSU request FSM, read-latency counter, request/response registers
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the address.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rstn,
    lsu_if.slave bus
);
    localparam logic [2:0] LAT_LAST = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

    lsu_state_t        state, state_nxt;
    logic              we_q, sext_q, trap_q;
    lsu_size_t         size_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [2:0]        cnt_q;

    lsu_size_t         size_in;
    logic [1:0]        off_in;
    logic              trap_in, accept, capture, strobe;
    logic [3:0]        be_al;
    logic [31:0]       wd_al, ld_al;

    // Offset is pre-masked to the access size so the aligner never sees a split lane.
    always_comb begin
        size_in = funct3_to_size(bus.i_We, bus.i_Funct3);
        off_in  = bus.i_Addr[1:0];
        case (size_in)
            SZ_H:    off_in = {bus.i_Addr[1], 1'b0};
            SZ_W:    off_in = 2'b00;
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_in   = (size_in == SZ_H && bus.i_Addr[0]) || (size_in == SZ_W && |bus.i_Addr[1:0]);
    assign bus.o_Err = trap_q && (state == DONE);
`else
    assign trap_in   = 1'b0;
    assign bus.o_Err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        strobe      = 1'b0;
        bus.o_Ready = 1'b0;
        bus.o_Done  = 1'b0;
        case (state)
            IDLE: begin
                bus.o_Ready = 1'b1;
                if (bus.i_Valid) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                strobe = !trap_q;
                if (trap_q || we_q) begin
                    state_nxt = DONE;
                end else if (MEM_LAT == 0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.o_Done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            trap_q  <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 3'd0;
        end else begin
            if (accept) begin
                we_q    <= bus.i_We;
                sext_q  <= !bus.i_Funct3[2];
                trap_q  <= trap_in;
                size_q  <= size_in;
                off_q   <= off_in;
                addr_q  <= {bus.i_Addr[ADDR_W-1:2], 2'b00};
                wdata_q <= bus.i_Wdata;
                rdata_q <= 32'h0;
            end
            if (state == ACCESS)    cnt_q <= 3'd0;
            else if (state == WAIT) cnt_q <= cnt_q + 3'd1;
            if (capture)            rdata_q <= ld_al;
        end
    end

    lsu_align u_align (
        .size  (size_q),
        .off   (off_q),
        .sext  (sext_q),
        .wdata (wdata_q),
        .rd    (bus.i_Rd),
        .be    (be_al),
        .wd    (wd_al),
        .ld    (ld_al)
    );

    assign bus.o_Ren   = strobe && !we_q;
    assign bus.o_Wen   = strobe && we_q;
    assign bus.o_Be    = strobe ? be_al : 4'h0;
    assign bus.o_Addr  = addr_q;
    assign bus.o_Wd    = wd_al;
    assign bus.o_Rdata = rdata_q;
endmodule
